axi_stream_transmitter: RTL and testbench

//  AXI4-Stream master: accepts one wide block (e.g. a SHA3 digest/state slice) over a simple

---
 rtl/sha3_axis_pkg.sv | 26 ++
 rtl/axi_stream_transmitter.sv | 181 ++++++++++++++++++
 tb/tb_axi_stream_transmitter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_axis_pkg.sv
// Shared definitions for the SHA3 AXI4-Stream transmitter and receiver.
// Holds the FSM state type, the default beat geometry and the byte-lane mask helper.
package sha3_axis_pkg;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_BLOCK_WIDTH = 256;
  localparam int DEF_BPB         = DEF_DATA_WIDTH / 8;
  localparam int DEF_MAX_BEATS   = DEF_BLOCK_WIDTH / DEF_DATA_WIDTH;
  localparam int KEEP_MAX        = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } axis_state_e;

  // LS-aligned mask with the low r lanes set; callers slice it to their beat width.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input logic [31:0] r);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      m[i] = (32'(i) < r);
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_transmitter.sv
// AXI4-Stream master that serialises one wide block into DATA_WIDTH beats, LS word first.
// A short final beat is flagged through TKEEP/TSTRB and a byte count on TUSER.
module axi_stream_transmitter
  import sha3_axis_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int ID_WIDTH    = 2
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic [BLOCK_WIDTH-1:0]             blk_data,
  input  logic [$clog2(BLOCK_WIDTH/8):0]     blk_bytes,
  input  logic [ID_WIDTH-1:0]                blk_id,
  input  logic                               blk_dest,
  input  logic                               blk_valid,
  output logic                               blk_ready,
  output logic [DATA_WIDTH-1:0]              TDATA,
  output logic                               TVALID,
  input  logic                               TREADY,
  output logic                               TLAST,
  output logic [DATA_WIDTH/8-1:0]            TKEEP,
  output logic [DATA_WIDTH/8-1:0]            TSTRB,
  output logic [ID_WIDTH-1:0]                TID,
  output logic                               TDEST,
  output logic [2:0]                         TUSER,
  output logic                               busy
);

  localparam int BPB       = DATA_WIDTH / 8;
  localparam int MAX_BYTES = BLOCK_WIDTH / 8;
  localparam int BYTES_W   = $clog2(MAX_BYTES) + 1;
  localparam int MAX_BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int BEAT_W    = $clog2(MAX_BEATS) + 1;
  localparam int REM_W     = $clog2(BPB) + 1;
  localparam logic [BYTES_W-1:0] MAX_BYTES_L = BYTES_W'(MAX_BYTES);

  axis_state_e state_q, state_d;
  logic [BLOCK_WIDTH-1:0] shreg_q, shreg_d;
  logic [BEAT_W-1:0]      beats_q, beats_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic                   blk_ready_q, blk_ready_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [BPB-1:0]         tkeep_q, tkeep_d;
  logic [ID_WIDTH-1:0]    tid_q, tid_d;
  logic                   tdest_q, tdest_d;
  logic [2:0]             tuser_q, tuser_d;

  logic [BYTES_W-1:0]     bytes_c;
  logic [BLOCK_WIDTH-1:0] masked;
  logic [BYTES_W:0]       beats_wide;
  logic [BYTES_W:0]       rem_wide;
  logic [BEAT_W-1:0]      load_beats;
  logic [REM_W-1:0]       load_rem;

  // Clamp the byte count and zero every lane past it, so short final beats carry zeros.
  always_comb begin
    bytes_c = (blk_bytes > MAX_BYTES_L) ? MAX_BYTES_L : blk_bytes;
    masked  = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      masked[i*8 +: 8] = (BYTES_W'(i) < bytes_c) ? blk_data[i*8 +: 8] : 8'h00;
    end
    beats_wide = ({1'b0, bytes_c} + (BYTES_W+1)'(BPB - 1)) / (BYTES_W+1)'(BPB);
    rem_wide   = {1'b0, bytes_c} - (beats_wide - (BYTES_W+1)'(1)) * (BYTES_W+1)'(BPB);
    load_beats = BEAT_W'(beats_wide);
    load_rem   = REM_W'(rem_wide);
  end

  logic                  emit;
  logic                  beat_is_last;
  logic [DATA_WIDTH-1:0] beat_word;
  logic [KEEP_MAX-1:0]   km;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    beats_d      = beats_q;
    rem_d        = rem_q;
    blk_ready_d  = blk_ready_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tkeep_d      = tkeep_q;
    tid_d        = tid_q;
    tdest_d      = tdest_q;
    tuser_d      = tuser_q;
    emit         = 1'b0;
    beat_is_last = 1'b0;
    beat_word    = '0;
    km           = '0;

    case (state_q)
      IDLE: begin
        blk_ready_d = 1'b1;
        if (blk_valid && blk_ready_q && (bytes_c != '0)) begin
          state_d      = SEND;
          blk_ready_d  = 1'b0;
          tvalid_d     = 1'b1;
          shreg_d      = masked >> DATA_WIDTH;
          beats_d      = load_beats;
          rem_d        = load_rem;
          tid_d        = blk_id;
          tdest_d      = blk_dest;
          emit         = 1'b1;
          beat_word    = masked[DATA_WIDTH-1:0];
          beat_is_last = (load_beats == BEAT_W'(1));
        end
      end
      SEND: begin
        // Outputs only move on a handshake, so a stalled beat stays frozen.
        if (TREADY) begin
          if (beats_q == BEAT_W'(1)) begin
            state_d     = IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            blk_ready_d = 1'b1;
          end else begin
            shreg_d      = shreg_q >> DATA_WIDTH;
            beats_d      = beats_q - BEAT_W'(1);
            emit         = 1'b1;
            beat_word    = shreg_q[DATA_WIDTH-1:0];
            beat_is_last = (beats_q == BEAT_W'(2));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      km      = keep_mask(32'(rem_d));
      tdata_d = beat_word;
      tlast_d = beat_is_last;
      tkeep_d = beat_is_last ? km[BPB-1:0] : '1;
      tuser_d = beat_is_last ? 3'(32'(rem_d) % 32'd8) : 3'd0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      beats_q     <= '0;
      rem_q       <= '0;
      blk_ready_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tkeep_q     <= '0;
      tid_q       <= '0;
      tdest_q     <= 1'b0;
      tuser_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      beats_q     <= beats_d;
      rem_q       <= rem_d;
      blk_ready_q <= blk_ready_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tkeep_q     <= tkeep_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      tuser_q     <= tuser_d;
    end
  end

  assign blk_ready = blk_ready_q;
  assign TDATA     = tdata_q;
  assign TVALID    = tvalid_q;
  assign TLAST     = tlast_q;
  assign TKEEP     = tkeep_q;
  assign TSTRB     = tkeep_q;
  assign TID       = tid_q;
  assign TDEST     = tdest_q;
  assign TUSER     = tuser_q;
  assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_axi_stream_transmitter.sv
// Scoreboard bench for axi_stream_transmitter: stimulus pushes hand-computed beats,
// a negedge monitor pops and compares each beat the DUT hands over.
module tb_axi_stream_transmitter;

  logic         ACLK;
  logic         ARESETn;
  logic [255:0] blk_data;
  logic [5:0]   blk_bytes;
  logic [1:0]   blk_id;
  logic         blk_dest;
  logic         blk_valid;
  logic         blk_ready;
  logic [63:0]  TDATA;
  logic         TVALID;
  logic         TREADY;
  logic         TLAST;
  logic [7:0]   TKEEP;
  logic [7:0]   TSTRB;
  logic [1:0]   TID;
  logic         TDEST;
  logic [2:0]   TUSER;
  logic         busy;

  axi_stream_transmitter #(
    .DATA_WIDTH (64),
    .BLOCK_WIDTH(256),
    .ID_WIDTH   (2)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .blk_data (blk_data),
    .blk_bytes(blk_bytes),
    .blk_id   (blk_id),
    .blk_dest (blk_dest),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .TDATA    (TDATA),
    .TVALID   (TVALID),
    .TREADY   (TREADY),
    .TLAST    (TLAST),
    .TKEEP    (TKEEP),
    .TSTRB    (TSTRB),
    .TID      (TID),
    .TDEST    (TDEST),
    .TUSER    (TUSER),
    .busy     (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  localparam logic [63:0] W0 = 64'h0706050403020100;
  localparam logic [63:0] W1 = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] W2 = 64'h1716151413121110;
  localparam logic [63:0] W3 = 64'h1F1E1D1C1B1A1918;
  localparam logic [255:0] BLOCK = {W3, W2, W1, W0};

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
    logic [2:0]  user;
    logic [1:0]  id;
    logic        dest;
  } beat_t;

  beat_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  logic  rand_mode    = 1'b0;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [63:0] d, input logic l, input logic [7:0] k,
                           input logic [2:0] u, input logic [1:0] id, input logic dst);
    beat_t b;
    b.data = d; b.last = l; b.keep = k; b.user = u; b.id = id; b.dest = dst;
    exp_q.push_back(b);
  endtask

  task automatic push_full(input logic [1:0] id, input logic dst);
    push_beat(W0, 1'b0, 8'hFF, 3'd0, id, dst);
    push_beat(W1, 1'b0, 8'hFF, 3'd0, id, dst);
    push_beat(W2, 1'b0, 8'hFF, 3'd0, id, dst);
    push_beat(W3, 1'b1, 8'hFF, 3'd0, id, dst);
  endtask

  task automatic apply_stimulus(input logic [255:0] d, input logic [5:0] nbytes,
                                input logic [1:0] id, input logic dst);
    int n = 0;
    while (!blk_ready && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    check_output("blk_ready_wait", 256'(blk_ready), 256'(1));
    blk_data  = d;
    blk_bytes = nbytes;
    blk_id    = id;
    blk_dest  = dst;
    blk_valid = 1'b1;
    @(posedge ACLK); #1;
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge ACLK); #1;
      n++;
    end
    check_output("drain_queue", 256'(exp_q.size()), 256'(0));
    repeat (2) begin
      @(posedge ACLK); #1;
    end
  endtask

  // Random sink back-pressure, only while the stall test owns TREADY.
  always @(posedge ACLK) begin
    if (rand_mode) begin
      #1;
      TREADY = 1'($urandom_range(0, 1));
    end
  end

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  logic [7:0]  prev_keep;
  logic [1:0]  prev_id;
  logic [2:0]  prev_user;
  logic        counting = 1'b0;
  int          gap_cnt  = 0;
  int          last_gap = -1;

  always @(negedge ACLK) begin
    beat_t e;
    if (!ARESETn) begin
      prev_stall = 1'b0;
      counting   = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("hold_tvalid", 256'(TVALID), 256'(1));
        check_output("hold_tdata", 256'(TDATA), 256'(prev_data));
        check_output("hold_tlast", 256'(TLAST), 256'(prev_last));
        check_output("hold_tkeep", 256'(TKEEP), 256'(prev_keep));
        check_output("hold_tid", 256'(TID), 256'(prev_id));
        check_output("hold_tuser", 256'(TUSER), 256'(prev_user));
      end
      if (TVALID && TREADY) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_beat", 256'(TDATA), 256'(0) - 256'(1));
        end else begin
          e = exp_q.pop_front();
          check_output("tdata", 256'(TDATA), 256'(e.data));
          check_output("tlast", 256'(TLAST), 256'(e.last));
          check_output("tkeep", 256'(TKEEP), 256'(e.keep));
          check_output("tstrb", 256'(TSTRB), 256'(e.keep));
          check_output("tuser", 256'(TUSER), 256'(e.user));
          check_output("tid", 256'(TID), 256'(e.id));
          check_output("tdest", 256'(TDEST), 256'(e.dest));
        end
      end
      if (TVALID && TREADY && TLAST) begin
        counting = 1'b1;
        gap_cnt  = 0;
      end else if (counting) begin
        if (!TVALID) gap_cnt++;
        else begin
          last_gap = gap_cnt;
          counting = 1'b0;
        end
      end
      prev_stall = TVALID && !TREADY;
      prev_data  = TDATA;
      prev_last  = TLAST;
      prev_keep  = TKEEP;
      prev_id    = TID;
      prev_user  = TUSER;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    ARESETn   = 1'b0;
    blk_data  = '0;
    blk_bytes = '0;
    blk_id    = '0;
    blk_dest  = 1'b0;
    blk_valid = 1'b0;
    TREADY    = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    check_output("rst_tvalid", 256'(TVALID), 256'(0));
    check_output("rst_tlast", 256'(TLAST), 256'(0));
    check_output("rst_tdata", 256'(TDATA), 256'(0));
    check_output("rst_tkeep", 256'(TKEEP), 256'(0));
    check_output("rst_tuser", 256'(TUSER), 256'(0));
    check_output("rst_busy", 256'(busy), 256'(0));
    check_output("rst_blk_ready", 256'(blk_ready), 256'(0));
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check_output("post_rst_blk_ready", 256'(blk_ready), 256'(1));
    TREADY = 1'b1;

    // Full 32-byte block at full throughput.
    push_full(2'd1, 1'b0);
    apply_stimulus(BLOCK, 6'd32, 2'd1, 1'b0);
    check_output("latency_tvalid", 256'(TVALID), 256'(1));
    check_output("accept_blk_ready", 256'(blk_ready), 256'(0));
    check_output("accept_busy", 256'(busy), 256'(1));
    drain();
    check_output("idle_tvalid", 256'(TVALID), 256'(0));
    check_output("idle_blk_ready", 256'(blk_ready), 256'(1));

    // 20 bytes: two full beats and a four-byte tail.
    push_beat(W0, 1'b0, 8'hFF, 3'd0, 2'd2, 1'b1);
    push_beat(W1, 1'b0, 8'hFF, 3'd0, 2'd2, 1'b1);
    push_beat(64'h0000000013121110, 1'b1, 8'h0F, 3'd4, 2'd2, 1'b1);
    apply_stimulus(BLOCK, 6'd20, 2'd2, 1'b1);
    drain();

    // Random back-pressure over a full block and a 13-byte block.
    rand_mode = 1'b1;
    push_full(2'd3, 1'b1);
    apply_stimulus(BLOCK, 6'd32, 2'd3, 1'b1);
    push_beat(W0, 1'b0, 8'hFF, 3'd0, 2'd0, 1'b0);
    push_beat(64'h0000000C0B0A0908, 1'b1, 8'h1F, 3'd5, 2'd0, 1'b0);
    apply_stimulus(BLOCK, 6'd13, 2'd0, 1'b0);
    drain();
    rand_mode = 1'b0;
    @(posedge ACLK); #1;
    TREADY = 1'b1;

    // Empty block is consumed with no beats.
    apply_stimulus(BLOCK, 6'd0, 2'd1, 1'b0);
    check_output("zero_tvalid", 256'(TVALID), 256'(0));
    check_output("zero_blk_ready", 256'(blk_ready), 256'(1));
    repeat (3) @(posedge ACLK);
    #1;
    check_output("zero_no_beats_tvalid", 256'(TVALID), 256'(0));

    // Oversized count clamps to the full block.
    push_full(2'd0, 1'b1);
    apply_stimulus(BLOCK, 6'd40, 2'd0, 1'b1);
    drain();

    // Back-to-back blocks: one idle cycle between them.
    last_gap = -1;
    push_beat(W0, 1'b0, 8'hFF, 3'd0, 2'd1, 1'b0);
    push_beat(W1, 1'b1, 8'hFF, 3'd0, 2'd1, 1'b0);
    push_beat(W0, 1'b0, 8'hFF, 3'd0, 2'd2, 1'b0);
    push_beat(W1, 1'b1, 8'hFF, 3'd0, 2'd2, 1'b0);
    apply_stimulus(BLOCK, 6'd16, 2'd1, 1'b0);
    apply_stimulus(BLOCK, 6'd16, 2'd2, 1'b0);
    drain();
    check_output("b2b_gap", 256'(last_gap), 256'(1));

    // Reset after two of four beats, then a fresh block starts at beat 0.
    TREADY = 1'b0;
    push_full(2'd3, 1'b0);
    apply_stimulus(BLOCK, 6'd32, 2'd3, 1'b0);
    TREADY = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    TREADY = 1'b0;
    check_output("mid_beats_left", 256'(exp_q.size()), 256'(2));
    exp_q.delete();
    ARESETn = 1'b0;
    #1;
    check_output("mid_rst_tvalid", 256'(TVALID), 256'(0));
    check_output("mid_rst_busy", 256'(busy), 256'(0));
    check_output("mid_rst_blk_ready", 256'(blk_ready), 256'(0));
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check_output("mid_post_blk_ready", 256'(blk_ready), 256'(1));
    check_output("mid_post_tvalid", 256'(TVALID), 256'(0));
    TREADY = 1'b1;
    push_full(2'd1, 1'b1);
    apply_stimulus(BLOCK, 6'd32, 2'd1, 1'b1);
    drain();

    check_output("final_queue_empty", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
